// File: rtl/slot_alloc_pkg.sv
// Shared constants and default-width slot types for the circular slot allocator.
package slot_alloc_pkg;
   localparam int SLOT_ALLOC_W_DEFAULT     = 32;
   localparam int SLOT_ALLOC_RADIX_DEFAULT = 4;

   typedef logic [$clog2(SLOT_ALLOC_W_DEFAULT)-1:0] slot_idx_t;
   typedef logic [SLOT_ALLOC_W_DEFAULT-1:0]         slot_vec_t;
endpackage

// File: rtl/slot_alloc_e.sv
// Circular left-most free-slot search: scans pos-1 down to 0, then wraps W-1 down to pos.
// Widths of 9 or more use a two-level tree of RADIX_N-wide groups.
module e
   import slot_alloc_pkg::*;
#(
   parameter int W       = SLOT_ALLOC_W_DEFAULT,
   parameter int RADIX_N = SLOT_ALLOC_RADIX_DEFAULT
) (
   input  logic [W-1:0]         x,
   input  logic [$clog2(W)-1:0] pos,
   output logic                 any,
   output logic [$clog2(W)-1:0] idx,
   output logic [W-1:0]         oh
);
   localparam int IW = $clog2(W);

   generate
      if (W < 2 || RADIX_N < 2 || RADIX_N > 8) begin : g_param_check
         $error("e: W must be >= 2 and RADIX_N must be in [2,8]");
      end
   endgenerate

   logic [W-1:0] free_v;
   logic [W-1:0] below;
   logic [W-1:0] sel;

   assign free_v = ~x;
   assign any    = |free_v;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_below
         assign below[gi] = free_v[gi] & (IW'(gi) < pos);
      end
   endgenerate

   // Slots strictly below the pointer win; otherwise the wrap-around half is searched.
   assign sel = (|below) ? below : free_v;

   function automatic logic [$clog2(RADIX_N)-1:0] grp_lmo(input logic [RADIX_N-1:0] v);
      grp_lmo = '0;
      for (int j = 0; j < RADIX_N; j++) begin
         if (v[j]) grp_lmo = $clog2(RADIX_N)'(j);
      end
   endfunction

   generate
      if (W < 9) begin : g_flat
         always_comb begin
            idx = '0;
            for (int i = 0; i < W; i++) begin
               if (sel[i]) idx = IW'(i);
            end
         end
      end else begin : g_tree
         localparam int R  = RADIX_N;
         localparam int NG = (W + R - 1) / R;
         localparam int LW = $clog2(R);

         logic [NG*R-1:0]        sel_pad;
         logic [NG-1:0]          grp_any;
         logic [NG-1:0][LW-1:0]  grp_idx;

         assign sel_pad = (NG*R)'(sel);

         for (gi = 0; gi < NG; gi++) begin : g_grp
            assign grp_any[gi] = |sel_pad[gi*R +: R];
            assign grp_idx[gi] = grp_lmo(sel_pad[gi*R +: R]);
         end

         always_comb begin
            idx = '0;
            for (int g = 0; g < NG; g++) begin
               if (grp_any[g]) idx = IW'(g*R) + IW'(grp_idx[g]);
            end
         end
      end
   endgenerate

   assign oh = any ? (W'(1) << idx) : '0;
endmodule

// File: rtl/slot_alloc.sv
// Circular free-slot allocator with valid/ready grant and a free/return port.
// Optional SLOT_ALLOC_CNT_EN adds cnt_o, a registered count of busy slots.
module slot_alloc
   import slot_alloc_pkg::*;
#(
   parameter int W       = SLOT_ALLOC_W_DEFAULT,
   parameter int RADIX_N = SLOT_ALLOC_RADIX_DEFAULT
) (
   input  logic                   clk,
   input  logic                   arst_n,
   output logic                   alloc_vld_o,
   input  logic                   alloc_rdy_i,
   output logic [$clog2(W)-1:0]   alloc_idx_o,
   output logic [W-1:0]           alloc_oh_o,
   input  logic                   free_vld_i,
   input  logic [$clog2(W)-1:0]   free_idx_i,
   input  logic                   flush_i,
   output logic [W-1:0]           occ_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   err_o
`ifdef SLOT_ALLOC_CNT_EN
   ,
   output logic [$clog2(W+1)-1:0] cnt_o
`endif
);
   localparam int IW = $clog2(W);

   logic [W-1:0]  occ_q;
   logic [W-1:0]  occ_next;
   logic [IW-1:0] ptr_q;
   logic          err_q;
   logic          accept;
   logic          in_range;
   logic          free_ok;

   e #(.W(W), .RADIX_N(RADIX_N)) u_search (
      .x   (occ_q),
      .pos (ptr_q),
      .any (alloc_vld_o),
      .idx (alloc_idx_o),
      .oh  (alloc_oh_o)
   );

   assign accept   = alloc_vld_o & alloc_rdy_i;
   assign in_range = {1'b0, free_idx_i} < (IW+1)'(W);
   assign free_ok  = free_vld_i & in_range & occ_q[free_idx_i];

   // The offered slot is idle, so it can never collide with a legal release.
   always_comb begin
      occ_next = occ_q;
      if (accept)  occ_next[alloc_idx_o] = 1'b1;
      if (free_ok) occ_next[free_idx_i]  = 1'b0;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         occ_q <= '0;
         ptr_q <= '0;
         err_q <= 1'b0;
      end else if (flush_i) begin
         occ_q <= '0;
         ptr_q <= '0;
         err_q <= 1'b0;
      end else begin
         occ_q <= occ_next;
         if (accept) ptr_q <= alloc_idx_o;
         if (free_vld_i && !free_ok) err_q <= 1'b1;
      end
   end

   assign occ_o   = occ_q;
   assign full_o  = &occ_q;
   assign empty_o = ~|occ_q;
   assign err_o   = err_q;

`ifdef SLOT_ALLOC_CNT_EN
   localparam int CW = $clog2(W+1);
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)      cnt_q <= '0;
      else if (flush_i) cnt_q <= '0;
      else              cnt_q <= cnt_q + CW'(accept) - CW'(free_ok);
   end

   assign cnt_o = cnt_q;

   cnt_matches_occ: assert property (@(posedge clk) disable iff (!arst_n)
      cnt_q == CW'($countones(occ_q)));
`endif
endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc at W=16; SLOT_ALLOC_CNT_EN builds add a randomised counter run.
module tb_slot_alloc;
   localparam int W  = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          alloc_rdy_i = 1'b0;
   logic          free_vld_i = 1'b0;
   logic [IW-1:0] free_idx_i = '0;
   logic          flush_i = 1'b0;
   logic          alloc_vld_o;
   logic [IW-1:0] alloc_idx_o;
   logic [W-1:0]  alloc_oh_o;
   logic [W-1:0]  occ_o;
   logic          full_o;
   logic          empty_o;
   logic          err_o;
`ifdef SLOT_ALLOC_CNT_EN
   logic [4:0]    cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   slot_alloc #(.W(W), .RADIX_N(4)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .alloc_vld_o (alloc_vld_o),
      .alloc_rdy_i (alloc_rdy_i),
      .alloc_idx_o (alloc_idx_o),
      .alloc_oh_o  (alloc_oh_o),
      .free_vld_i  (free_vld_i),
      .free_idx_i  (free_idx_i),
      .flush_i     (flush_i),
      .occ_o       (occ_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .err_o       (err_o)
`ifdef SLOT_ALLOC_CNT_EN
      ,
      .cnt_o       (cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      arst_n = 1'b0;
      repeat (3) @(negedge clk);
      arst_n = 1'b1;
      #1;
      $display("reset released occ=%h vld=%0b idx=%0d", occ_o, alloc_vld_o, alloc_idx_o);
      checks++; if (occ_o !== 16'h0000) begin failures++; $display("FAIL reset_occ: got %h expected 0000", occ_o); end
      checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin failures++; $display("FAIL reset_flags: empty=%b full=%b expected 1 0", empty_o, full_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_o); end
      checks++; if (alloc_vld_o !== 1'b1 || alloc_idx_o !== 4'd15) begin failures++; $display("FAIL reset_offer: vld=%b idx=%0d expected 1 15", alloc_vld_o, alloc_idx_o); end
   endtask

   task automatic test_fill();
      logic [IW-1:0] exp_idx;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         alloc_rdy_i = 1'b1;
         exp_idx = IW'(15 - k);
         $display("grant vld=%0b idx=%0d oh=%h", alloc_vld_o, alloc_idx_o, alloc_oh_o);
         checks++; if (alloc_vld_o !== 1'b1 || alloc_idx_o !== exp_idx) begin failures++; $display("FAIL fill_idx: vld=%b idx=%0d expected 1 %0d", alloc_vld_o, alloc_idx_o, exp_idx); end
         checks++; if (alloc_oh_o !== (16'h1 << exp_idx)) begin failures++; $display("FAIL fill_oh: got %h expected %h", alloc_oh_o, 16'h1 << exp_idx); end
      end
      @(negedge clk);
      $display("full occ=%h full=%0b vld=%0b", occ_o, full_o, alloc_vld_o);
      checks++; if (occ_o !== 16'hFFFF || full_o !== 1'b1) begin failures++; $display("FAIL fill_full: occ=%h full=%b expected FFFF 1", occ_o, full_o); end
      checks++; if (alloc_vld_o !== 1'b0 || empty_o !== 1'b0) begin failures++; $display("FAIL fill_novld: vld=%b empty=%b expected 0 0", alloc_vld_o, empty_o); end
      @(negedge clk);
      alloc_rdy_i = 1'b0;
      $display("ready while full occ=%h err=%0b", occ_o, err_o);
      checks++; if (occ_o !== 16'hFFFF || err_o !== 1'b0) begin failures++; $display("FAIL rdy_no_vld: occ=%h err=%b expected FFFF 0", occ_o, err_o); end
   endtask

   task automatic test_accept_and_free();
      free_vld_i = 1'b1; free_idx_i = 4'd15;
      @(negedge clk);
      $display("free 15 -> offer vld=%0b idx=%0d", alloc_vld_o, alloc_idx_o);
      checks++; if (alloc_vld_o !== 1'b1 || alloc_idx_o !== 4'd15) begin failures++; $display("FAIL af_offer15: vld=%b idx=%0d expected 1 15", alloc_vld_o, alloc_idx_o); end
      alloc_rdy_i = 1'b1; free_vld_i = 1'b1; free_idx_i = 4'd3;
      @(negedge clk);
      alloc_rdy_i = 1'b0; free_vld_i = 1'b0;
      $display("accept 15 + free 3 occ=%h err=%0b next=%0d", occ_o, err_o, alloc_idx_o);
      checks++; if (occ_o !== 16'hFFF7) begin failures++; $display("FAIL af_occ: got %h expected FFF7", occ_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL af_err: got %b expected 0", err_o); end
      checks++; if (alloc_idx_o !== 4'd3) begin failures++; $display("FAIL af_next: got %0d expected 3", alloc_idx_o); end
      alloc_rdy_i = 1'b1;
      @(negedge clk);
      alloc_rdy_i = 1'b0;
      $display("accept 3 occ=%h", occ_o);
      checks++; if (occ_o !== 16'hFFFF) begin failures++; $display("FAIL af_refill: got %h expected FFFF", occ_o); end
   endtask

   task automatic test_free_reuse();
      free_vld_i = 1'b1; free_idx_i = 4'd8;
      #1;
      checks++; if (alloc_vld_o !== 1'b0) begin failures++; $display("FAIL reuse_same_cycle: vld=%b expected 0", alloc_vld_o); end
      @(negedge clk);
      free_vld_i = 1'b0;
      $display("free 8 occ=%h offer=%0d", occ_o, alloc_idx_o);
      checks++; if (occ_o !== 16'hFEFF) begin failures++; $display("FAIL reuse_occ: got %h expected FEFF", occ_o); end
      checks++; if (alloc_vld_o !== 1'b1 || alloc_idx_o !== 4'd8) begin failures++; $display("FAIL reuse_offer: vld=%b idx=%0d expected 1 8", alloc_vld_o, alloc_idx_o); end
      alloc_rdy_i = 1'b1;
      @(negedge clk);
      alloc_rdy_i = 1'b0;
      $display("accept 8 occ=%h", occ_o);
      checks++; if (occ_o !== 16'hFFFF) begin failures++; $display("FAIL reuse_full: got %h expected FFFF", occ_o); end
   endtask

   task automatic test_pattern();
      logic [IW-1:0] frees [8];
      frees = '{4'd8, 4'd15, 4'd14, 4'd12, 4'd10, 4'd7, 4'd6, 4'd3};
      for (int i = 0; i < 8; i++) begin
         free_vld_i = 1'b1; free_idx_i = frees[i];
         $display("free idx=%0d", frees[i]);
         @(negedge clk);
      end
      free_vld_i = 1'b0;
      $display("pattern occ=%h offer=%0d oh=%h", occ_o, alloc_idx_o, alloc_oh_o);
      checks++; if (occ_o !== 16'h2A37) begin failures++; $display("FAIL pat_occ: got %h expected 2A37", occ_o); end
      checks++; if (alloc_vld_o !== 1'b1 || alloc_idx_o !== 4'd7) begin failures++; $display("FAIL pat_idx: vld=%b idx=%0d expected 1 7", alloc_vld_o, alloc_idx_o); end
      checks++; if (alloc_oh_o !== 16'h0080) begin failures++; $display("FAIL pat_oh: got %h expected 0080", alloc_oh_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL pat_err: got %b expected 0", err_o); end
   endtask

   task automatic test_err_flush();
      free_vld_i = 1'b1; free_idx_i = 4'd5;
      @(negedge clk);
      checks++; if (occ_o !== 16'h2A17 || err_o !== 1'b0) begin failures++; $display("FAIL err_first_free: occ=%h err=%b expected 2A17 0", occ_o, err_o); end
      free_vld_i = 1'b1; free_idx_i = 4'd5;
      @(negedge clk);
      free_vld_i = 1'b0;
      $display("free idle 5 occ=%h err=%0b", occ_o, err_o);
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set: got %b expected 1", err_o); end
      checks++; if (occ_o !== 16'h2A17) begin failures++; $display("FAIL err_occ: got %h expected 2A17", occ_o); end
      @(negedge clk);
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err_o); end
      flush_i = 1'b1; alloc_rdy_i = 1'b1; free_vld_i = 1'b1; free_idx_i = 4'd13;
      @(negedge clk);
      flush_i = 1'b0; alloc_rdy_i = 1'b0; free_vld_i = 1'b0;
      $display("flush occ=%h err=%0b offer=%0d", occ_o, err_o, alloc_idx_o);
      checks++; if (occ_o !== 16'h0000 || empty_o !== 1'b1) begin failures++; $display("FAIL flush_occ: occ=%h empty=%b expected 0000 1", occ_o, empty_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL flush_err: got %b expected 0", err_o); end
      checks++; if (alloc_vld_o !== 1'b1 || alloc_idx_o !== 4'd15) begin failures++; $display("FAIL flush_offer: vld=%b idx=%0d expected 1 15", alloc_vld_o, alloc_idx_o); end
   endtask

   task automatic test_async_reset();
      alloc_rdy_i = 1'b1;
      @(negedge clk);
      $display("grant before reset occ=%h", occ_o);
      checks++; if (occ_o !== 16'h8000) begin failures++; $display("FAIL ar_pre: got %h expected 8000", occ_o); end
      #2 arst_n = 1'b0;
      #1;
      $display("async reset occ=%h offer=%0d", occ_o, alloc_idx_o);
      checks++; if (occ_o !== 16'h0000 || alloc_idx_o !== 4'd15) begin failures++; $display("FAIL ar_immediate: occ=%h idx=%0d expected 0000 15", occ_o, alloc_idx_o); end
      @(negedge clk);
      checks++; if (occ_o !== 16'h0000) begin failures++; $display("FAIL ar_held: got %h expected 0000", occ_o); end
      arst_n = 1'b1; alloc_rdy_i = 1'b0;
      @(negedge clk);
      checks++; if (occ_o !== 16'h0000 || alloc_idx_o !== 4'd15 || err_o !== 1'b0) begin failures++; $display("FAIL ar_release: occ=%h idx=%0d err=%b expected 0000 15 0", occ_o, alloc_idx_o, err_o); end
   endtask

`ifdef SLOT_ALLOC_CNT_EN
   task automatic test_cnt_random();
      logic [W-1:0] model;
      logic         do_flush, do_rdy, do_free, f_ok;
      logic [IW-1:0] fidx;
      model = '0;
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         checks++; if (occ_o !== model || cnt_o !== 5'($countones(model))) begin failures++; $display("FAIL cnt_cycle%0d: occ=%h cnt=%0d expected %h %0d", n, occ_o, cnt_o, model, $countones(model)); end
         do_flush = ($urandom_range(0, 63) == 0);
         do_rdy   = 1'($urandom_range(0, 1));
         do_free  = 1'($urandom_range(0, 1));
         fidx     = IW'($urandom_range(0, W-1));
         flush_i = do_flush; alloc_rdy_i = do_rdy; free_vld_i = do_free; free_idx_i = fidx;
         if (do_flush) model = '0;
         else begin
            f_ok = do_free && model[fidx];
            if (alloc_vld_o && do_rdy) model[alloc_idx_o] = 1'b1;
            if (f_ok) model[fidx] = 1'b0;
         end
      end
      @(negedge clk);
      flush_i = 1'b0; alloc_rdy_i = 1'b0; free_vld_i = 1'b0;
      $display("random counter run done");
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_accept_and_free();
      test_free_reuse();
      test_pattern();
      test_err_flush();
      test_async_reset();
`ifdef SLOT_ALLOC_CNT_EN
      test_cnt_random();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
